ex_pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the execute stage of the five-stage core. Each cycle it decides whether the PC, IF/ID, ID/EX and EX/MEM latches advance, stall, or are squashed. The decision is based on load-use hazards against the instruction in execute, taken branches and jumps resolved in execute, data-memory stalls, and the halt/dump instruction. It replaces the scattered per-stage enable logic with one FSM, and can optionally count stall and flush cycles.

---
 rtl/ex_pipe_ctrl.sv | 119 +++++++++++
 tb/tb_ex_pipe_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_pipe_ctrl.sv
// Execute-stage pipeline sequencing controller: latch enables, squashes, redirect and halt.
// Optional stall/flush performance counters are enabled by defining EX_PERF_CNT_EN.
module ex_pipe_ctrl #(
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [2:0]        id_rs,
  input  logic [2:0]        id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic [2:0]        ex_rd,
  input  logic              brchcnd,
  input  logic              alujmp,
  input  logic              ex_jmp,
  input  logic              dmp,
  input  logic              mem_stall,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_write,
  output logic              exmem_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              redirect,
  output logic              halted,
  output logic [1:0]        state
`ifdef EX_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } state_t;

  state_t cur_state, nxt_state;
  logic   lu_haz, take;

  if (PERF_W < 1) begin : g_perf_w_check
    $error("PERF_W must be at least 1");
  end

  assign lu_haz = id_valid & ex_valid & ex_memread &
                  ((id_rs_used & (id_rs == ex_rd)) | (id_rt_used & (id_rt == ex_rd)));
  assign take   = ex_valid & (brchcnd | alujmp | ex_jmp);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cur_state <= RUN;
    else      cur_state <= nxt_state;
  end

  // MEM_WAIT with mem_stall low behaves exactly like RUN, so it shares the RUN event chain.
  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    idex_write  = 1'b0;
    exmem_write = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    redirect    = 1'b0;
    nxt_state   = cur_state;
    if (!rst) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      nxt_state  = RUN;
    end else if (cur_state == HALT) begin
      idex_flush  = 1'b1;
      exmem_write = ~mem_stall;
      nxt_state   = HALT;
    end else if (mem_stall) begin
      nxt_state = MEM_WAIT;
    end else if (ex_valid & dmp) begin
      idex_flush  = 1'b1;
      exmem_write = 1'b1;
      nxt_state   = HALT;
    end else if (take) begin
      redirect    = 1'b1;
      pc_write    = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_write = 1'b1;
      nxt_state   = RUN;
    end else if (lu_haz && cur_state != LU_STALL) begin
      idex_flush  = 1'b1;
      exmem_write = 1'b1;
      nxt_state   = LU_STALL;
    end else begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_write  = 1'b1;
      exmem_write = 1'b1;
      nxt_state   = RUN;
    end
  end

  assign halted = (cur_state == HALT);
  assign state  = cur_state;

`ifdef EX_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write && !halted) stall_cnt <= stall_cnt + PERF_W'(1);
      if (redirect)             flush_cnt <= flush_cnt + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ex_pipe_ctrl.sv
// Self-checking bench for ex_pipe_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a flag-based behavioural model.
module tb_ex_pipe_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs_used, id_rt_used, ex_valid, ex_memread;
  logic [2:0] id_rs, id_rt, ex_rd;
  logic       brchcnd, alujmp, ex_jmp, dmp, mem_stall;
  logic       pc_write, ifid_write, idex_write, exmem_write;
  logic       ifid_flush, idex_flush, redirect, halted;
  logic [1:0] state;
`ifdef EX_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // model state: halted / waiting on memory / one bubble just inserted
  bit m_halt, m_mw, m_lu;
  bit n_halt, n_mw, n_lu;
  bit [15:0] m_sc, m_fc;
  bit e_pc, e_ifw, e_idw, e_exw, e_iff, e_idf, e_red, e_halt;
  int e_state;
  int halt_age;

  ex_pipe_ctrl #(.PERF_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .brchcnd(brchcnd), .alujmp(alujmp), .ex_jmp(ex_jmp), .dmp(dmp),
    .mem_stall(mem_stall),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .redirect(redirect), .halted(halted), .state(state)
`ifdef EX_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
    ex_valid = 0; ex_memread = 0; ex_rd = 0;
    brchcnd = 0; alujmp = 0; ex_jmp = 0; dmp = 0; mem_stall = 0;
  endtask

  task automatic rand_inputs();
    id_valid   = ($urandom_range(0, 3) != 0);
    id_rs      = 3'($urandom_range(0, 7));
    id_rt      = 3'($urandom_range(0, 7));
    id_rs_used = 1'($urandom_range(0, 1));
    id_rt_used = 1'($urandom_range(0, 1));
    ex_valid   = ($urandom_range(0, 3) != 0);
    ex_memread = 1'($urandom_range(0, 1));
    ex_rd      = 3'($urandom_range(0, 3));
    brchcnd    = ($urandom_range(0, 5) == 0);
    alujmp     = ($urandom_range(0, 15) == 0);
    ex_jmp     = ($urandom_range(0, 15) == 0);
    dmp        = ($urandom_range(0, 79) == 0);
    mem_stall  = ($urandom_range(0, 4) == 0);
  endtask

  // Expected outputs and next model flags from the priority rules.
  task automatic eval_model();
    bit lu, tk;
    {e_pc, e_ifw, e_idw, e_exw, e_iff, e_idf, e_red, e_halt} = '0;
    n_halt = m_halt; n_mw = 0; n_lu = 0;
    lu = id_valid && ex_valid && ex_memread &&
         ((id_rs_used && id_rs == ex_rd) || (id_rt_used && id_rt == ex_rd));
    tk = ex_valid && (brchcnd || alujmp || ex_jmp);
    e_state = m_halt ? 3 : m_mw ? 2 : m_lu ? 1 : 0;
    if (!rst) begin
      e_iff = 1; e_idf = 1; e_state = 0; n_halt = 0;
    end else if (m_halt) begin
      e_idf = 1; e_exw = !mem_stall; e_halt = 1;
    end else if (mem_stall) begin
      n_mw = 1;
    end else if (ex_valid && dmp) begin
      e_idf = 1; e_exw = 1; n_halt = 1;
    end else if (tk) begin
      e_red = 1; e_pc = 1; e_iff = 1; e_idf = 1; e_exw = 1;
    end else if (lu && !m_lu) begin
      e_idf = 1; e_exw = 1; n_lu = 1;
    end else begin
      e_pc = 1; e_ifw = 1; e_idw = 1; e_exw = 1;
    end
  endtask

  task automatic compare();
    eval_model();
    chk("pc_write", pc_write, e_pc);
    chk("ifid_write", ifid_write, e_ifw);
    chk("idex_write", idex_write, e_idw);
    chk("exmem_write", exmem_write, e_exw);
    chk("ifid_flush", ifid_flush, e_iff);
    chk("idex_flush", idex_flush, e_idf);
    chk("redirect", redirect, e_red);
    chk("halted", halted, e_halt);
    chk("state", state, e_state);
`ifdef EX_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, m_sc);
    chk("flush_cnt", flush_cnt, m_fc);
`endif
  endtask

  task automatic commit();
    @(posedge clk);
    if (!rst) begin
      m_halt = 0; m_mw = 0; m_lu = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (!e_pc && !e_halt) m_sc = m_sc + 16'd1;
      if (e_red) m_fc = m_fc + 16'd1;
      m_halt = n_halt; m_mw = n_mw; m_lu = n_lu;
    end
    #1;
  endtask

  task automatic cycle();
    #4;
    compare();
    commit();
  endtask

  task automatic do_reset();
    rst = 0;
    clear_inputs();
    cycle();
    rst = 1;
  endtask

  task automatic set_load_use();
    clear_inputs();
    id_valid = 1; ex_valid = 1; ex_memread = 1; ex_rd = 3; id_rs = 3; id_rs_used = 1;
  endtask

  initial begin
    rst = 0;
    clear_inputs();
    m_halt = 0; m_mw = 0; m_lu = 0; m_sc = 0; m_fc = 0;
    #4;
    chk("rst_state", state, 0);
    chk("rst_pc_write", pc_write, 0);
    chk("rst_idex_flush", idex_flush, 1);
    chk("rst_halted", halted, 0);
    compare();
    commit();
    rst = 1;

    // load-use: one bubble, then back to RUN
    set_load_use();
    #4; compare();
    chk("lu_pc_write", pc_write, 0);
    chk("lu_idex_flush", idex_flush, 1);
    commit();
    ex_valid = 0;
    #4; compare();
    chk("lu_state", state, 1);
    chk("lu_bubble_pc", pc_write, 1);
    commit();
    clear_inputs();
    #4; compare();
    chk("lu_after_state", state, 0);
    chk("lu_after_idex_write", idex_write, 1);
    commit();

    // taken branch overriding a load-use hazard
    set_load_use(); brchcnd = 1;
    #4; compare();
    chk("br_redirect", redirect, 1);
    chk("br_ifid_flush", ifid_flush, 1);
    chk("br_pc_write", pc_write, 1);
    commit();
    clear_inputs();
    #4; compare();
    chk("br_no_lustall", state, 0);
    commit();

    // 3-cycle memory stall deferring a taken branch
    ex_valid = 1; brchcnd = 1; mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #4; compare();
      chk("ms_exmem_write", exmem_write, 0);
      chk("ms_redirect", redirect, 0);
      commit();
    end
    mem_stall = 0;
    #4; compare();
    chk("ms_state", state, 2);
    chk("ms_redirect_after", redirect, 1);
    commit();

    // reset asynchronously while in MEM_WAIT
    clear_inputs(); mem_stall = 1;
    cycle();
    #2 rst = 0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_pc_write", pc_write, 0);
    chk("arst_ifid_flush", ifid_flush, 1);
    chk("arst_idex_flush", idex_flush, 1);
    #1; compare();
    commit();
    rst = 1;
    clear_inputs();

    // halt is sticky
    ex_valid = 1; dmp = 1;
    #4; compare();
    chk("dmp_pc_write", pc_write, 0);
    chk("dmp_halted_early", halted, 0);
    commit();
    clear_inputs();
    #4; compare();
    chk("halt_state", state, 3);
    chk("halt_halted", halted, 1);
    commit();
    for (int i = 0; i < 100; i++) begin
      rand_inputs();
      #4; compare();
      chk("halt_sticky", halted, 1);
      commit();
    end
    do_reset();

`ifdef EX_PERF_CNT_EN
    for (int i = 0; i < 2; i++) begin
      set_load_use(); cycle();
      clear_inputs(); cycle();
    end
    mem_stall = 1;
    for (int i = 0; i < 3; i++) cycle();
    clear_inputs(); ex_valid = 1; brchcnd = 1; cycle();
    clear_inputs();
    #4;
    chk("perf_stall_cnt", stall_cnt, 5);
    chk("perf_flush_cnt", flush_cnt, 1);
    compare();
    commit();
    do_reset();
`endif

    // randomized traffic with occasional resets
    halt_age = 0;
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      rst = !(($urandom_range(0, 299) == 0) || halt_age > 120);
      cycle();
      halt_age = m_halt ? halt_age + 1 : 0;
      rst = 1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
